rob_completion_arbiter: RTL and testbench



---
 rtl/rob_pkg.sv | 28 ++
 rtl/rob_completion_arbiter_rr_arbiter.sv | 39 +++
 rtl/rob_completion_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_rob_completion_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// ROB-side shared types and constants for completion / writeback arbitration.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package rob_pkg;

    localparam int ROB_TAG_W    = 5;
    localparam int ROB_ENTRIES  = 32;
    localparam int ROB_DATA_W   = 64;
    localparam int ROB_SRC_W    = 3;

    // Starvation wait counters saturate at the top of this width.
    localparam int                    STARVE_CNT_W   = 3;
    localparam logic [STARVE_CNT_W-1:0] STARVE_CNT_MAX = '1;

    // One completion record as seen by the ROB writeback port.
    typedef struct packed {
        logic [ROB_TAG_W-1:0]  tag;
        logic [ROB_DATA_W-1:0] data;
        logic [ROB_SRC_W-1:0]  src;
    } rob_cmp_t;

    // Output register occupancy.
    typedef enum logic {
        CMP_EMPTY = 1'b0,
        CMP_FULL  = 1'b1
    } cmp_state_e;

endpackage

// File: rtl/rob_completion_arbiter_rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr, wrapping modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: enable low forces an empty grant.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_vld
);

    logic [IDX_W:0] scan_idx;

    // Scan ptr, ptr+1, ... with an explicit compare-and-subtract wrap so non-power-of-2 sizes work.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        scan_idx  = '0;
        if (enable) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scan_idx = {1'b0, ptr} + (IDX_W+1)'(k);
                if (scan_idx >= (IDX_W+1)'(NUM_REQ)) begin
                    scan_idx = scan_idx - (IDX_W+1)'(NUM_REQ);
                end
                if (!grant_vld && req[scan_idx[IDX_W-1:0]]) begin
                    grant[scan_idx[IDX_W-1:0]] = 1'b1;
                    grant_idx                  = scan_idx[IDX_W-1:0];
                    grant_vld                  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rob_completion_arbiter.sv
// Shares the ROB completion port among NUM_REQ units, round-robin, into a 1-entry output register. Optional macro ROB_ARB_STARVE_EN adds a starvation boost.
// Latency: 1 cycle from req_valid&&req_ready to cmp_valid; 1 completion/cycle sustained with no bubble.
// Backpressure: req_ready only while the output register is empty or draining this cycle (cmp_ready); flush blocks grants.
module rob_completion_arbiter
    import rob_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int TAG_W        = ROB_TAG_W,
    parameter int DATA_W       = ROB_DATA_W,
    parameter int STARVE_LIMIT = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        flush,
    output logic                        cmp_valid,
    output logic [TAG_W-1:0]            cmp_tag,
    output logic [DATA_W-1:0]           cmp_data,
    output logic [$clog2(NUM_REQ)-1:0]  cmp_src,
    input  logic                        cmp_ready
);

    localparam int SRC_W = $clog2(NUM_REQ);

    // Reject out-of-range configurations at elaboration.
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("rob_completion_arbiter: NUM_REQ must be 2..8");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_starve_limit
        $error("rob_completion_arbiter: STARVE_LIMIT must be 1..7");
    end

    cmp_state_e         state_q, state_d;
    logic               can_load;
    logic               arb_en;

    logic [SRC_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] rr_grant;
    logic [SRC_W-1:0]   rr_idx;
    logic               rr_vld;

    logic [NUM_REQ-1:0] grant;
    logic [SRC_W-1:0]   grant_idx;
    logic               grant_vld;

    logic [TAG_W-1:0]   tag_arr  [NUM_REQ];
    logic [DATA_W-1:0]  data_arr [NUM_REQ];

    logic [TAG_W-1:0]   tag_q;
    logic [DATA_W-1:0]  data_q;
    logic [SRC_W-1:0]   src_q;

    // Unpack the flat request buses so the winner can be selected by index.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign tag_arr[g]  = req_tag[g*TAG_W +: TAG_W];
        assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    end

    // Arbitration is only open when the output slot can take a new entry; reset and flush close it.
    assign arb_en = can_load && !flush && !rst;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (SRC_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .enable    (arb_en),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .grant_vld (rr_vld)
    );

`ifdef ROB_ARB_STARVE_EN
    logic [STARVE_CNT_W-1:0] wait_cnt [NUM_REQ];
    logic [NUM_REQ-1:0]      starved;

    // A unit counts as starved only while it is still requesting.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            starved[i] = req_valid[i] && (wait_cnt[i] >= STARVE_CNT_W'(STARVE_LIMIT));
        end
    end

    // Lowest-index starved unit overrides the round-robin choice.
    always_comb begin
        grant     = rr_grant;
        grant_idx = rr_idx;
        grant_vld = rr_vld;
        if (arb_en && (|starved)) begin
            grant     = '0;
            grant_idx = '0;
            grant_vld = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_vld && starved[i]) begin
                    grant[i]  = 1'b1;
                    grant_idx = SRC_W'(i);
                    grant_vld = 1'b1;
                end
            end
        end
    end

    // Saturating per-unit wait counters: count refused cycles, clear on grant, idle or flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (flush || !req_valid[i] || grant[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != STARVE_CNT_MAX) begin
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    // Pure round-robin grant.
    always_comb begin
        grant     = rr_grant;
        grant_idx = rr_idx;
        grant_vld = rr_vld;
    end
`endif

    assign req_ready = grant;

    // Output FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CMP_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output FSM next state: flush empties, a grant fills (also overwriting a drained entry), a drain empties.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = CMP_EMPTY;
        end else if (grant_vld) begin
            state_d = CMP_FULL;
        end else if (state_q == CMP_FULL && cmp_ready) begin
            state_d = CMP_EMPTY;
        end
    end

    // Output FSM outputs: a new entry fits when empty or when the current one leaves this cycle.
    always_comb begin
        cmp_valid = (state_q == CMP_FULL);
        can_load  = (state_q == CMP_EMPTY) || cmp_ready;
    end

    // Capture the winner's payload and advance the pointer past it; flush leaves both untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q  <= '0;
            data_q <= '0;
            src_q  <= '0;
            rr_ptr <= '0;
        end else if (grant_vld) begin
            tag_q  <= tag_arr[grant_idx];
            data_q <= data_arr[grant_idx];
            src_q  <= grant_idx;
            rr_ptr <= (grant_idx == SRC_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    assign cmp_tag  = tag_q;
    assign cmp_data = data_q;
    assign cmp_src  = src_q;

endmodule

// File: tb/tb_rob_completion_arbiter.sv
// Bench for rob_completion_arbiter: directed vector table, hand sequences and a randomized run against a reference model.
// Latency: expects completions one cycle after each grant.
// Backpressure: exercised through cmp_ready stalls and flush.
module tb_rob_completion_arbiter;

    localparam int N  = 4;
    localparam int TW = 5;
    localparam int DW = 64;
    localparam int SL = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*TW-1:0] req_tag = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            flush = 1'b0;
    logic            cmp_valid;
    logic [TW-1:0]   cmp_tag;
    logic [DW-1:0]   cmp_data;
    logic [1:0]      cmp_src;
    logic            cmp_ready = 1'b0;

    rob_completion_arbiter #(
        .NUM_REQ      (N),
        .TAG_W        (TW),
        .DATA_W       (DW),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_ready (req_ready),
        .flush     (flush),
        .cmp_valid (cmp_valid),
        .cmp_tag   (cmp_tag),
        .cmp_data  (cmp_data),
        .cmp_src   (cmp_src),
        .cmp_ready (cmp_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [N-1:0]  u_vld;
    logic [TW-1:0] u_tag [N];
    logic [DW-1:0] u_dat [N];

    // Reference model state
    logic          m_full;
    logic [TW-1:0] m_tag;
    logic [DW-1:0] m_data;
    int            m_src;
    int            m_ptr;
    int            m_wait [N];

    typedef struct packed {
        logic [3:0]  vld;
        logic [19:0] tags;
        logic        crdy;
        logic        fl;
        logic [3:0]  exp_rdy;
        logic        exp_cvld;
        logic [4:0]  exp_tag;
        logic [1:0]  exp_src;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] dat_of(input logic [TW-1:0] t);
        return {32'hD00DF00D, 27'h0, t};
    endfunction

    task automatic drive();
        req_valid = u_vld;
        for (int i = 0; i < N; i++) begin
            req_tag[i*TW +: TW]  = u_tag[i];
            req_data[i*DW +: DW] = u_dat[i];
        end
    endtask

    task automatic clear_units();
        u_vld = '0;
        for (int i = 0; i < N; i++) begin
            u_tag[i] = '0;
            u_dat[i] = '0;
        end
    endtask

    // Reference grant: starved-lowest-index first (when enabled), else first valid from the pointer, modulo N.
    function automatic int model_grant(input logic [N-1:0] v, input logic crdy, input logic fl);
        int g;
        g = -1;
        if ((!m_full || crdy) && !fl) begin
`ifdef ROB_ARB_STARVE_EN
            for (int i = 0; i < N; i++) begin
                if (g < 0 && v[i] && m_wait[i] >= SL) g = i;
            end
`endif
            for (int k = 0; k < N; k++) begin
                if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        return g;
    endfunction

    task automatic model_step(input logic [N-1:0] v, input logic crdy, input logic fl, input int g);
        for (int i = 0; i < N; i++) begin
            if (fl || !v[i] || i == g) m_wait[i] = 0;
            else if (m_wait[i] < 7) m_wait[i] = m_wait[i] + 1;
        end
        if (fl) begin
            m_full = 1'b0;
        end else if (g >= 0) begin
            m_full = 1'b1;
            m_tag  = u_tag[g];
            m_data = u_dat[g];
            m_src  = g;
            m_ptr  = (g + 1) % N;
        end else if (m_full && crdy) begin
            m_full = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_tag  = '0;
        m_data = '0;
        m_src  = 0;
        m_ptr  = 0;
        for (int i = 0; i < N; i++) m_wait[i] = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        flush = 1'b0;
        cmp_ready = 1'b0;
        clear_units();
        u_vld = 4'b1111;
        drive();
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_cmp_valid", 64'(cmp_valid), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        u_vld = '0;
        drive();
        model_reset();
    endtask

    localparam logic [19:0] T_FAIR = {5'd15, 5'd11, 5'd7, 5'd3};
    localparam logic [19:0] T_B    = {5'd0, 5'd9, 5'd20, 5'd5};

    logic [3:0] sv_exp [4];
    int         last_g;
    int         g;
    logic [N-1:0] exp_rdy;

    initial begin
        //                vld      tags    crdy fl  exp_rdy cvld tag    src
        tbl[0]  = '{4'b1111, T_FAIR, 1'b1, 1'b0, 4'b0001, 1'b0, 5'd0,  2'd0};
        tbl[1]  = '{4'b1111, T_FAIR, 1'b1, 1'b0, 4'b0010, 1'b1, 5'd3,  2'd0};
        tbl[2]  = '{4'b1111, T_FAIR, 1'b1, 1'b0, 4'b0100, 1'b1, 5'd7,  2'd1};
        tbl[3]  = '{4'b1111, T_FAIR, 1'b1, 1'b0, 4'b1000, 1'b1, 5'd11, 2'd2};
        tbl[4]  = '{4'b0001, T_FAIR, 1'b1, 1'b0, 4'b0001, 1'b1, 5'd15, 2'd3};
        tbl[5]  = '{4'b0100, T_B,    1'b1, 1'b0, 4'b0100, 1'b1, 5'd3,  2'd0};
        tbl[6]  = '{4'b0010, T_B,    1'b0, 1'b0, 4'b0000, 1'b1, 5'd9,  2'd2};
        tbl[7]  = '{4'b0010, T_B,    1'b0, 1'b0, 4'b0000, 1'b1, 5'd9,  2'd2};
        tbl[8]  = '{4'b0010, T_B,    1'b0, 1'b0, 4'b0000, 1'b1, 5'd9,  2'd2};
        tbl[9]  = '{4'b0010, T_B,    1'b0, 1'b0, 4'b0000, 1'b1, 5'd9,  2'd2};
        tbl[10] = '{4'b0010, T_B,    1'b1, 1'b0, 4'b0010, 1'b1, 5'd9,  2'd2};
        tbl[11] = '{4'b0001, T_B,    1'b0, 1'b0, 4'b0000, 1'b1, 5'd20, 2'd1};
        tbl[12] = '{4'b0001, T_B,    1'b0, 1'b1, 4'b0000, 1'b1, 5'd20, 2'd1};
        tbl[13] = '{4'b0001, T_B,    1'b0, 1'b0, 4'b0001, 1'b0, 5'd20, 2'd1};
        tbl[14] = '{4'b0000, T_B,    1'b1, 1'b0, 4'b0000, 1'b1, 5'd5,  2'd0};
        tbl[15] = '{4'b0000, T_B,    1'b1, 1'b0, 4'b0000, 1'b0, 5'd5,  2'd0};

        clear_units();
        drive();

        // Reset and idle
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chk("idle_cmp_valid", 64'(cmp_valid), 64'h0);
            chk("idle_req_ready", 64'(req_ready), 64'h0);
        end

        // Directed vector table: fairness, backpressure, flush
        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            u_vld = tbl[r].vld;
            for (int i = 0; i < N; i++) begin
                u_tag[i] = tbl[r].tags[i*TW +: TW];
                u_dat[i] = dat_of(u_tag[i]);
            end
            cmp_ready = tbl[r].crdy;
            flush     = tbl[r].fl;
            drive();
            #1;
            chk($sformatf("tbl%0d_req_ready", r), 64'(req_ready), 64'(tbl[r].exp_rdy));
            chk($sformatf("tbl%0d_cmp_valid", r), 64'(cmp_valid), 64'(tbl[r].exp_cvld));
            chk($sformatf("tbl%0d_cmp_tag", r), 64'(cmp_tag), 64'(tbl[r].exp_tag));
            chk($sformatf("tbl%0d_cmp_src", r), 64'(cmp_src), 64'(tbl[r].exp_src));
            if (tbl[r].exp_cvld) begin
                chk($sformatf("tbl%0d_cmp_data", r), cmp_data, dat_of(tbl[r].exp_tag));
            end
        end
        flush = 1'b0;

        // Starvation scenario: unit 3 holds valid, units 0,1,2 each raise once in turn and drop when granted
`ifdef ROB_ARB_STARVE_EN
        sv_exp[0] = 4'b0001; sv_exp[1] = 4'b0010; sv_exp[2] = 4'b1000; sv_exp[3] = 4'b0100;
`else
        sv_exp[0] = 4'b0001; sv_exp[1] = 4'b0010; sv_exp[2] = 4'b0100; sv_exp[3] = 4'b1000;
`endif
        do_reset();
        for (int i = 0; i < N; i++) begin
            u_tag[i] = 5'(16 + i);
            u_dat[i] = dat_of(u_tag[i]);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c < 3) u_vld[c] = 1'b1;
            if (c == 0) u_vld[3] = 1'b1;
            cmp_ready = 1'b1;
            drive();
            #1;
            chk($sformatf("starve_c%0d_grant", c + 1), 64'(req_ready), 64'(sv_exp[c]));
            u_vld = u_vld & ~sv_exp[c];
        end

        // Async reset mid-stream
        @(negedge clk);
        clear_units();
        u_vld = 4'b0010;
        u_tag[1] = 5'd13;
        u_dat[1] = dat_of(5'd13);
        cmp_ready = 1'b1;
        drive();
        #1;
        chk("arst_pre_grant", 64'(req_ready), 64'h2);
        @(negedge clk);
        u_vld = 4'b0100;
        cmp_ready = 1'b0;
        drive();
        #1;
        chk("arst_pre_cmp_valid", 64'(cmp_valid), 64'h1);
        chk("arst_pre_cmp_tag", 64'(cmp_tag), 64'd13);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_cmp_valid", 64'(cmp_valid), 64'h0);
        chk("arst_cmp_tag", 64'(cmp_tag), 64'h0);
        chk("arst_req_ready", 64'(req_ready), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        u_vld = 4'b1111;
        cmp_ready = 1'b1;
        drive();
        #1;
        chk("arst_ptr_zero", 64'(req_ready), 64'h1);

        // Randomized run against the reference model
        do_reset();
        last_g = -1;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (u_vld[i] && last_g == i) u_vld[i] = 1'b0;
                else if (u_vld[i] && $urandom_range(0, 19) == 0) u_vld[i] = 1'b0;
                if (!u_vld[i] && $urandom_range(0, 9) < 6) begin
                    u_vld[i] = 1'b1;
                    u_tag[i] = 5'($urandom);
                    u_dat[i] = {$urandom, $urandom};
                end
            end
            flush     = ($urandom_range(0, 99) < 6);
            cmp_ready = ($urandom_range(0, 9) < 7);
            drive();
            #1;
            g = model_grant(u_vld, cmp_ready, flush);
            exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
            chk("rnd_req_ready", 64'(req_ready), 64'(exp_rdy));
            chk("rnd_cmp_valid", 64'(cmp_valid), 64'(m_full));
            chk("rnd_cmp_tag", 64'(cmp_tag), 64'(m_tag));
            chk("rnd_cmp_data", cmp_data, m_data);
            chk("rnd_cmp_src", 64'(cmp_src), 64'(m_src));
            model_step(u_vld, cmp_ready, flush, g);
            last_g = g;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
